// File: rtl/uart_tx_arbiter_if.sv
// Producer/TX-core handshake bundle for uart_tx_arbiter.
// master = environment (producers + TX core), slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][7:0]  req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     tx_busy;

  modport master (output req, req_data, tx_busy, input ack, tx_start, tx_data);
  modport slave  (input req, req_data, tx_busy, output ack, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX core between NUM_REQ byte producers.
// Optional UART_ARB_ID_HEADER_EN: prefix every granted byte with header 8'hA0|grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int START_TIMEOUT = 15,
  parameter int TO_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
`ifdef UART_ARB_ID_HEADER_EN
    , HDR_NEXT = 2'd3
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      last, last_d, grant_d, win;
  logic                 win_vld, grant, to_hit;
  logic [TO_W-1:0]      cnt, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 start_q, start_d, to_d;
  logic [7:0]           data_q, data_d;
`ifdef UART_ARB_ID_HEADER_EN
  logic [7:0]           hold, hold_d;
  logic                 hdr_pend, hdr_pend_d;
`endif

  assign bus.ack      = ack_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign busy         = (state != IDLE);

  // Rotating search: first set req at or after last+1, wrapping.
  always_comb begin : arb
    logic [ID_W-1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(last) + off) % NUM_REQ);
      if (!win_vld && bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign grant  = (state == IDLE) && win_vld && !bus.tx_busy;
  assign to_hit = (cnt == TO_W'(START_TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)  state_nxt = WAIT_DONE;
        else if (to_hit)  state_nxt = IDLE;
      end
      WAIT_DONE: begin
`ifdef UART_ARB_ID_HEADER_EN
        if (!bus.tx_busy) state_nxt = hdr_pend ? HDR_NEXT : IDLE;
`else
        if (!bus.tx_busy) state_nxt = IDLE;
`endif
      end
`ifdef UART_ARB_ID_HEADER_EN
      HDR_NEXT:  state_nxt = WAIT_BUSY;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; everything leaves the block registered.
  always_comb begin
    ack_d   = '0;
    start_d = 1'b0;
    to_d    = 1'b0;
    data_d  = data_q;
    grant_d = grant_id;
    last_d  = last;
    cnt_d   = cnt;
`ifdef UART_ARB_ID_HEADER_EN
    hold_d     = hold;
    hdr_pend_d = hdr_pend;
`endif
    case (state)
      IDLE: if (grant) begin
        ack_d[win] = 1'b1;
        start_d    = 1'b1;
        grant_d    = win;
        last_d     = win;
        cnt_d      = '0;
`ifdef UART_ARB_ID_HEADER_EN
        data_d     = 8'hA0 | 8'(win);
        hold_d     = bus.req_data[win];
        hdr_pend_d = 1'b1;
`else
        data_d     = bus.req_data[win];
`endif
      end
      WAIT_BUSY: if (!bus.tx_busy) begin
        if (to_hit) begin
          // Byte dropped; pointer keeps its advance so a dead requester can't hog.
          to_d = 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
          hdr_pend_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_ARB_ID_HEADER_EN
      HDR_NEXT: begin
        data_d     = hold;
        start_d    = 1'b1;
        cnt_d      = '0;
        hdr_pend_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= '0;
      start_q     <= 1'b0;
      timeout_err <= 1'b0;
      data_q      <= 8'h00;
      grant_id    <= '0;
      last        <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
`ifdef UART_ARB_ID_HEADER_EN
      hold        <= 8'h00;
      hdr_pend    <= 1'b0;
`endif
    end else begin
      ack_q       <= ack_d;
      start_q     <= start_d;
      timeout_err <= to_d;
      data_q      <= data_d;
      grant_id    <= grant_d;
      last        <= last_d;
      cnt         <= cnt_d;
`ifdef UART_ARB_ID_HEADER_EN
      hold        <= hold_d;
      hdr_pend    <= hdr_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: rotation table plus hand-written corner sequences.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4, ID_W = 2, START_TIMEOUT = 15, TO_W = 4;
  localparam int BUSY_LEN = 12;
`ifdef UART_ARB_ID_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [ID_W-1:0] grant_id;
  logic            busy, timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .START_TIMEOUT(START_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // TX core model: goes busy the cycle after tx_start for BUSY_LEN cycles
  logic core_en, force_busy;
  int   core_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)                           core_cnt <= 0;
    else if (bus.tx_start && core_en)   core_cnt <= BUSY_LEN;
    else if (core_cnt != 0)             core_cnt <= core_cnt - 1;
  end
  assign bus.tx_busy = force_busy | (core_cnt != 0);

  logic [7:0] slog [0:255];
  int n_start = 0, n_ack = 0;
  always @(posedge clk) begin
    if (bus.tx_start) begin
      slog[n_start & 255] <= bus.tx_data;
      n_start <= n_start + 1;
    end
    if (bus.ack != '0) n_ack <= n_ack + 1;
  end

  int checks = 0, failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_first(input logic [1:0] id, input logic [7:0] b);
    logic [7:0] h;
    h = 8'hA0 | 8'(id);
    return HDR ? h : b;
  endfunction

  task automatic wait_ack(input int bound, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 1; i <= bound && !got; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin got = 1'b1; lat = i; end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},      32'(bus.ack), 32'd0);
    check({tag, "_start"},    32'(bus.tx_start), 32'd0);
    check({tag, "_data"},     32'(bus.tx_data), 32'd0);
    check({tag, "_grant"},    32'(grant_id), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_timeout"},  32'(timeout_err), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  id;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, base_s, base_a;
    bit ok, seen;
    logic [7:0] b;

    tbl[0] = '{4'b1111, 32'h13121110, 2'd0};
    tbl[1] = '{4'b1111, 32'h13121110, 2'd1};
    tbl[2] = '{4'b1111, 32'h13121110, 2'd2};
    tbl[3] = '{4'b1111, 32'h13121110, 2'd3};
    tbl[4] = '{4'b1111, 32'h13121110, 2'd0};
    tbl[5] = '{4'b0100, 32'h13121110, 2'd2};
    tbl[6] = '{4'b0101, 32'h13121110, 2'd0};
    tbl[7] = '{4'b0101, 32'h13121110, 2'd2};
    tbl[8] = '{4'b1000, 32'h13121110, 2'd3};
    tbl[9] = '{4'b0011, 32'h13121110, 2'd0};

    bus.req = '0; bus.req_data = '0; core_en = 1'b1; force_busy = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;

    // First grant latency and busy tail
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = 32'h00000055;
    @(negedge clk);
    check("lat_ack",   32'(bus.ack), 32'h1);
    check("lat_start", 32'(bus.tx_start), 32'd1);
    check("lat_data",  32'(bus.tx_data), 32'(exp_first(2'd0, 8'h55)));
    check("lat_grant", 32'(grant_id), 32'd0);
    check("lat_busy",  32'(busy), 32'd1);
    bus.req = '0;
    @(negedge clk);
    check("lat_ack_pulse", 32'(bus.ack), 32'd0);
    if (!HDR) begin
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (!bus.tx_busy) seen = 1'b1;
      end
      check("tail_busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      check("tail_busy_fall", 32'(busy), 32'd0);
    end else begin
      wait_idle(200);
    end

    // Rotation / wrap table, reset so requester 0 leads
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int v = 0; v < 10; v++) begin
      bus.req = tbl[v].req; bus.req_data = tbl[v].data;
      wait_ack(5, lat);
      b = 8'(tbl[v].data >> (8 * tbl[v].id));
      check($sformatf("v%0d_lat", v),   32'(lat), 32'd1);
      check($sformatf("v%0d_ack", v),   32'(bus.ack), 32'(4'b0001 << tbl[v].id));
      check($sformatf("v%0d_start", v), 32'(bus.tx_start), 32'd1);
      check($sformatf("v%0d_grant", v), 32'(grant_id), 32'(tbl[v].id));
      check($sformatf("v%0d_data", v),  32'(bus.tx_data), 32'(exp_first(tbl[v].id, b)));
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", v), 32'(bus.ack), 32'd0);
      wait_idle(200);
    end
    bus.req = '0;

    // Core never goes busy: timeout, then pointer keeps its advance
    core_en = 1'b0;
    bus.req = 4'b0010; bus.req_data = 32'hDDCCBBAA;
    wait_ack(5, lat);
    check("to_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (timeout_err) k = i;
    end
    check("to_delay", 32'(k), 32'(START_TIMEOUT + 1));
    check("to_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("to_pulse", 32'(timeout_err), 32'd0);
    core_en = 1'b1;
    bus.req = 4'b0110;
    wait_ack(5, lat);
    check("after_to_ack", 32'(bus.ack), 32'h4);
    check("after_to_data", 32'(bus.tx_data), 32'(exp_first(2'd2, 8'hCC)));
    bus.req = '0;
    wait_idle(200);

    // tx_busy high in IDLE blocks the grant
    force_busy = 1'b1;
    bus.req = 4'b0001;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.tx_start) ok = 1'b0;
    end
    check("hold_off", 32'(ok), 32'd1);
    force_busy = 1'b0;
    @(negedge clk);
    check("release_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    wait_idle(200);

    // Reset mid-frame
    bus.req = 4'b1000; bus.req_data = 32'h3C000000;
    wait_ack(5, lat);
    bus.req = '0;
    repeat (4) @(negedge clk);
    check("mid_grant", 32'(grant_id), 32'd3);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk); rst = 1'b1;
    bus.req = 4'b1001; bus.req_data = 32'h3C00005A;
    wait_ack(5, lat);
    check("post_rst_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    wait_idle(200);

    // Whole grant: header + data when enabled, single byte otherwise
    base_s = n_start; base_a = n_ack;
    bus.req = 4'b1000; bus.req_data = 32'h3C000000;
    wait_ack(5, lat);
    check("frm_grant", 32'(grant_id), 32'd3);
    check("frm_first", 32'(bus.tx_data), 32'(HDR ? 8'hA3 : 8'h3C));
    bus.req = '0;
    wait_idle(300);
    check("frm_starts", 32'(n_start - base_s), HDR ? 32'd2 : 32'd1);
    check("frm_acks",   32'(n_ack - base_a), 32'd1);
    check("frm_log0",   32'(slog[base_s & 255]), 32'(HDR ? 8'hA3 : 8'h3C));
    check("frm_last",   32'(slog[(n_start - 1) & 255]), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
